// File: rtl/uart_num_parser.sv
// ASCII decimal token parser: turns a UART byte stream into signed/unsigned binary values,
// flagging bad characters, overlong tokens and out-of-range values with a cause code.
//
// state | meaning
// IDLE  | between tokens, accumulator clear
// SIGN  | leading '-' seen, waiting for the first digit
// DIGIT | accumulating digits
// SKIP  | token already rejected, swallowing bytes until a delimiter
module uart_num_parser #(
  parameter int DATA_W     = 16,
  parameter bit SIGNED     = 1'b1,
  parameter int MAX_DIGITS = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              num_valid,
  output logic [DATA_W-1:0] num_value,
  output logic              num_err,
  output logic [1:0]        err_code,
  output logic              busy,
  output logic [7:0]        tok_cnt
);

  localparam int AW = DATA_W + 4;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);
  localparam logic [AW-1:0] LIM_U   = {{4{1'b0}}, {DATA_W{1'b1}}};
  localparam logic [AW-1:0] LIM_POS = {{5{1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic [AW-1:0] LIM_NEG = LIM_POS + AW'(1);
  localparam logic [1:0] E_BAD   = 2'd1;
  localparam logic [1:0] E_LONG  = 2'd2;
  localparam logic [1:0] E_RANGE = 2'd3;

  typedef enum logic [1:0] {IDLE, SIGN, DIGIT, SKIP} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              ovf_q, ovf_d;
  logic [1:0]        code_q, code_d;
  logic              num_valid_d, num_err_d;
  logic [DATA_W-1:0] num_value_d;
  logic [1:0]        err_code_d;
  logic [7:0]        tok_cnt_d;

  logic              is_digit, is_minus, is_delim, in_range;
  logic [AW-1:0]     dval, acc_mac;
  logic [DATA_W-1:0] mag, signed_val;

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_minus = (rx_data == 8'h2D);
  assign is_delim = (rx_data == 8'h20) || (rx_data == 8'h0D) ||
                    (rx_data == 8'h0A) || (rx_data == 8'h2C);
  assign dval     = {{(AW-4){1'b0}}, rx_data[3:0]};
  assign acc_mac  = (acc_q << 3) + (acc_q << 1) + dval;

  // ovf_q freezes the accumulator once it exceeds every legal magnitude, so it never wraps
  assign in_range = !ovf_q && (!SIGNED ? (acc_q <= LIM_U) :
                               neg_q   ? (acc_q <= LIM_NEG) : (acc_q <= LIM_POS));
  assign mag        = acc_q[DATA_W-1:0];
  assign signed_val = neg_q ? -mag : mag;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    code_d      = code_q;
    num_valid_d = 1'b0;
    num_err_d   = 1'b0;
    num_value_d = num_value;
    err_code_d  = err_code;
    tok_cnt_d   = tok_cnt;

    if (clr) begin
      state_d = IDLE;
    end else if (rx_valid) begin
      unique case (state_q)
        IDLE: begin
          if (is_digit) begin
            acc_d   = dval;
            cnt_d   = ONE_CNT;
            state_d = DIGIT;
          end else if (is_minus && SIGNED) begin
            neg_d   = 1'b1;
            state_d = SIGN;
          end else if (!is_delim) begin
            code_d  = E_BAD;
            state_d = SKIP;
          end
        end
        SIGN: begin
          if (is_digit) begin
            acc_d   = dval;
            cnt_d   = ONE_CNT;
            state_d = DIGIT;
          end else if (is_delim) begin
            num_err_d  = 1'b1;
            err_code_d = E_BAD;
            state_d    = IDLE;
          end else begin
            code_d  = E_BAD;
            state_d = SKIP;
          end
        end
        DIGIT: begin
          if (is_digit) begin
            if (cnt_q == MAX_CNT) begin
              code_d  = E_LONG;
              state_d = SKIP;
            end else begin
              cnt_d = cnt_q + ONE_CNT;
              if (!ovf_q) begin
                acc_d = acc_mac;
                ovf_d = (acc_mac > LIM_U);
              end
            end
          end else if (is_delim) begin
            if (in_range) begin
              num_valid_d = 1'b1;
              num_value_d = signed_val;
              tok_cnt_d   = tok_cnt + 8'd1;
            end else begin
              num_err_d  = 1'b1;
              err_code_d = E_RANGE;
            end
            state_d = IDLE;
          end else begin
            code_d  = E_BAD;
            state_d = SKIP;
          end
        end
        SKIP: begin
          if (is_delim) begin
            num_err_d  = 1'b1;
            err_code_d = code_q;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (state_d == IDLE) begin
      acc_d  = '0;
      cnt_d  = '0;
      neg_d  = 1'b0;
      ovf_d  = 1'b0;
      code_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      code_q    <= '0;
      num_valid <= 1'b0;
      num_err   <= 1'b0;
      num_value <= '0;
      err_code  <= '0;
      tok_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
      code_q    <= code_d;
      num_valid <= num_valid_d;
      num_err   <= num_err_d;
      num_value <= num_value_d;
      err_code  <= err_code_d;
      tok_cnt   <= tok_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_num_parser.sv
// Bench for uart_num_parser: a signed 16-bit and an unsigned 8-bit instance driven side by side,
// checked every cycle against a token-level model plus literal expectations from hand-worked strings.
module tb_uart_num_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr0 = 1'b0, rv0 = 1'b0, clr1 = 1'b0, rv1 = 1'b0;
  logic [7:0]  rd0 = 8'h0, rd1 = 8'h0;
  logic        nv0, ne0, bz0, nv1, ne1, bz1;
  logic [15:0] val0;
  logic [7:0]  val1;
  logic [1:0]  ec0, ec1;
  logic [7:0]  tc0, tc1;

  always #5 clk = ~clk;

  uart_num_parser #(.DATA_W(16), .SIGNED(1'b1), .MAX_DIGITS(5)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr0), .rx_valid(rv0), .rx_data(rd0),
    .num_valid(nv0), .num_value(val0), .num_err(ne0), .err_code(ec0),
    .busy(bz0), .tok_cnt(tc0));

  uart_num_parser #(.DATA_W(8), .SIGNED(1'b0), .MAX_DIGITS(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr1), .rx_valid(rv1), .rx_data(rd1),
    .num_valid(nv1), .num_value(val1), .num_err(ne1), .err_code(ec1),
    .busy(bz1), .tok_cnt(tc1));

  typedef struct packed {
    logic [1:0]  kind;   // 1 value, 2 error
    logic [1:0]  code;
    logic [31:0] val;
  } res_t;

  int errors = 0;
  int checks = 0;

  logic [7:0]  tq0[$], tq1[$];
  logic [35:0] ev0[$], ev1[$];
  logic        m_valid[2], m_err[2], m_busy[2];
  logic [31:0] m_val[2];
  logic [1:0]  m_code[2];
  logic [7:0]  m_cnt[2];
  logic        p_v0 = 1'b0, p_c0 = 1'b0, p_v1 = 1'b0, p_c1 = 1'b0;
  logic [7:0]  p_d0 = 8'h0, p_d1 = 8'h0;

  // Judge a whole token at once from its characters.
  function automatic res_t eval_tok(input logic [7:0] q[$], input int dw, input bit sg);
    longint     mag = 0;
    longint     lim;
    int         digits = 0;
    bit         neg = 1'b0;
    logic [1:0] code = 2'd0;
    res_t       r = '0;
    for (int i = 0; i < q.size(); i++) begin
      if (code != 2'd0) continue;
      if (q[i] >= 8'h30 && q[i] <= 8'h39) begin
        if (digits == 5) code = 2'd2;
        else begin
          digits++;
          mag = mag * 10 + longint'(q[i] - 8'h30);
        end
      end else if (q[i] == 8'h2D && i == 0 && sg) neg = 1'b1;
      else code = 2'd1;
    end
    if (code == 2'd0 && digits == 0) code = 2'd1;
    if (code == 2'd0) begin
      if (!sg) lim = (longint'(1) << dw) - 1;
      else if (neg) lim = longint'(1) << (dw - 1);
      else lim = (longint'(1) << (dw - 1)) - 1;
      if (mag > lim) code = 2'd3;
    end
    if (code != 2'd0) begin
      r.kind = 2'd2;
      r.code = code;
    end else begin
      r.kind = 2'd1;
      r.val  = 32'(neg ? ((longint'(1) << dw) - mag) % (longint'(1) << dw) : mag);
    end
    return r;
  endfunction

  task automatic model_reset();
    tq0.delete();
    tq1.delete();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0; m_err[k] = 1'b0; m_busy[k] = 1'b0;
      m_val[k] = '0; m_code[k] = '0; m_cnt[k] = '0;
    end
    p_v0 = 1'b0; p_c0 = 1'b0; p_d0 = '0;
    p_v1 = 1'b0; p_c1 = 1'b0; p_d1 = '0;
  endtask

  task automatic model_one(input int k, input logic c, input logic v, input logic [7:0] d);
    logic [7:0] q[$];
    res_t r;
    if (k == 0) q = tq0; else q = tq1;
    m_valid[k] = 1'b0;
    m_err[k]   = 1'b0;
    if (c) q.delete();
    else if (v) begin
      if (d == 8'h20 || d == 8'h0D || d == 8'h0A || d == 8'h2C) begin
        if (q.size() != 0) begin
          r = eval_tok(q, (k == 0) ? 16 : 8, k == 0);
          if (r.kind == 2'd1) begin
            m_valid[k] = 1'b1;
            m_val[k]   = r.val;
            m_cnt[k]   = m_cnt[k] + 8'd1;
          end else begin
            m_err[k]  = 1'b1;
            m_code[k] = r.code;
          end
          q.delete();
        end
      end else q.push_back(d);
    end
    m_busy[k] = (q.size() != 0);
    if (k == 0) tq0 = q; else tq1 = q;
  endtask

  task automatic compare_all();
    logic        a_v, a_e, a_b;
    logic [31:0] a_val;
    logic [1:0]  a_c;
    logic [7:0]  a_t;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        a_v = nv0; a_e = ne0; a_b = bz0; a_val = {16'h0, val0}; a_c = ec0; a_t = tc0;
      end else begin
        a_v = nv1; a_e = ne1; a_b = bz1; a_val = {24'h0, val1}; a_c = ec1; a_t = tc1;
      end
      checks++;
      if (a_v !== m_valid[k] || a_e !== m_err[k] || a_b !== m_busy[k] ||
          a_val !== m_val[k] || a_c !== m_code[k] || a_t !== m_cnt[k]) begin
        errors++;
        $display("FAIL cycle_dut%0d t=%0t got v=%0b e=%0b busy=%0b val=%0h code=%0d cnt=%0d want v=%0b e=%0b busy=%0b val=%0h code=%0d cnt=%0d",
                 k, $time, a_v, a_e, a_b, a_val, a_c, a_t,
                 m_valid[k], m_err[k], m_busy[k], m_val[k], m_code[k], m_cnt[k]);
      end
      if (a_v) begin
        if (k == 0) ev0.push_back({2'd1, 2'd0, a_val}); else ev1.push_back({2'd1, 2'd0, a_val});
      end
      if (a_e) begin
        if (k == 0) ev0.push_back({2'd2, a_c, 32'h0}); else ev1.push_back({2'd2, a_c, 32'h0});
      end
    end
  endtask

  // One clock: model consumes the inputs just clocked in, outputs are checked, next inputs driven.
  task automatic tick(input logic v0, input logic [7:0] d0, input logic c0,
                      input logic v1, input logic [7:0] d1, input logic c1);
    @(posedge clk);
    #1;
    model_one(0, p_c0, p_v0, p_d0);
    model_one(1, p_c1, p_v1, p_d1);
    compare_all();
    rv0 = v0; rd0 = d0; clr0 = c0;
    rv1 = v1; rd1 = d1; clr1 = c1;
    p_v0 = v0; p_d0 = d0; p_c0 = c0;
    p_v1 = v1; p_d1 = d1; p_c1 = c1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'h0, 1'b0, 1'b0, 8'h0, 1'b0);
  endtask

  task automatic send(input int k, input string s, input int maxgap);
    for (int i = 0; i < s.len(); i++) begin
      if (k == 0) tick(1'b1, s[i], 1'b0, 1'b0, 8'h0, 1'b0);
      else        tick(1'b0, 8'h0, 1'b0, 1'b1, s[i], 1'b0);
      idle($urandom_range(0, maxgap));
    end
    idle(2);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic expect_ev(input int k, input string name, input logic [1:0] kind,
                           input logic [1:0] code, input logic [31:0] val);
    logic [35:0] e;
    checks++;
    if ((k == 0 ? ev0.size() : ev1.size()) == 0) begin
      errors++;
      $display("FAIL %s got no pulse want kind=%0d code=%0d val=%0h", name, kind, code, val);
    end else begin
      if (k == 0) e = ev0.pop_front(); else e = ev1.pop_front();
      if (e !== {kind, code, val}) begin
        errors++;
        $display("FAIL %s got kind=%0d code=%0d val=%0h want kind=%0d code=%0d val=%0h",
                 name, e[35:34], e[33:32], e[31:0], kind, code, val);
      end
    end
  endtask

  task automatic expect_none(input int k, input string name);
    chk(name, (k == 0) ? ev0.size() : ev1.size(), 0);
    if (k == 0) ev0.delete(); else ev1.delete();
  endtask

  initial begin
    logic [7:0] b0, b1;
    int         r;
    model_reset();
    #23;
    chk("reset_outputs0", {nv0, ne0, bz0, ec0, tc0, val0}, 32'h0);
    chk("reset_outputs1", {nv1, ne1, bz1, ec1, tc1, val1}, 32'h0);
    rst_n = 1'b1;
    idle(2);

    send(0, "10 20 30 40 ", 1);
    expect_ev(0, "seq_10", 2'd1, 2'd0, 32'd10);
    expect_ev(0, "seq_20", 2'd1, 2'd0, 32'd20);
    expect_ev(0, "seq_30", 2'd1, 2'd0, 32'd30);
    expect_ev(0, "seq_40", 2'd1, 2'd0, 32'd40);
    expect_none(0, "seq_extra");
    chk("seq_tok_cnt", tc0, 32'd4);

    send(0, "-32768\r", 0);
    expect_ev(0, "min_neg", 2'd1, 2'd0, 32'h8000);
    send(0, "32768 ", 0);
    expect_ev(0, "pos_range", 2'd2, 2'd3, 32'h0);
    chk("value_held", val0, 32'h8000);
    expect_none(0, "range_extra");

    send(0, "123456", 0);
    chk("busy_long", bz0, 32'd1);
    expect_none(0, "long_early");
    send(0, " ", 0);
    expect_ev(0, "too_long", 2'd2, 2'd2, 32'h0);
    expect_none(0, "long_extra");

    send(0, "1x2 ,- ,  7\n", 1);
    expect_ev(0, "bad_char", 2'd2, 2'd1, 32'h0);
    expect_ev(0, "lone_minus", 2'd2, 2'd1, 32'h0);
    expect_ev(0, "after_delims", 2'd1, 2'd0, 32'd7);
    expect_none(0, "delim_extra");

    send(1, "255 256 -1 ", 1);
    expect_ev(1, "u8_max", 2'd1, 2'd0, 32'd255);
    expect_ev(1, "u8_range", 2'd2, 2'd3, 32'h0);
    expect_ev(1, "u8_minus", 2'd2, 2'd1, 32'h0);
    expect_none(1, "u8_extra");
    chk("u8_tok_cnt", tc1, 32'd1);

    send(0, "98", 0);
    tick(1'b0, 8'h0, 1'b1, 1'b0, 8'h0, 1'b0);
    send(0, "7 ", 0);
    expect_ev(0, "clr_then_7", 2'd1, 2'd0, 32'd7);
    tick(1'b1, "5", 1'b1, 1'b0, 8'h0, 1'b0);
    send(0, " ", 0);
    expect_none(0, "clr_drops_byte");

    send(0, "-0 ", 0);
    expect_ev(0, "minus_zero", 2'd1, 2'd0, 32'd0);

    send(0, "12", 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", bz0, 32'd0);
    chk("midreset_regs", {tc0, ec0, val0}, 32'h0);
    model_reset();
    #3;
    rst_n = 1'b1;
    idle(4);
    expect_none(0, "after_reset");

    for (int n = 0; n < 500; n++) begin
      for (int k = 0; k < 2; k++) begin
        r = $urandom_range(0, 99);
        if (r < 55)      b1 = 8'h30 + 8'($urandom_range(0, 9));
        else if (r < 63) b1 = 8'h2D;
        else if (r < 88) begin
          case ($urandom_range(0, 3))
            0: b1 = 8'h20;
            1: b1 = 8'h0D;
            2: b1 = 8'h0A;
            default: b1 = 8'h2C;
          endcase
        end else b1 = 8'($urandom_range(8'h41, 8'h5A));
        if (k == 0) b0 = b1;
      end
      tick($urandom_range(0, 3) != 0, b0, $urandom_range(0, 40) == 0,
           $urandom_range(0, 3) != 0, b1, $urandom_range(0, 40) == 0);
    end
    idle(3);
    ev0.delete();
    ev1.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
